// File: rtl/plb_cache_pkg.sv
// Shared types and defaults for the protection lookaside buffer storage.
package plb_cache_pkg;

    localparam int unsigned PLB_NUM_ENTRIES = 8;
    localparam int unsigned PLB_DATA_WIDTH  = 64;
    localparam int unsigned PLB_ADDR_WIDTH  = 64;
    localparam int unsigned PLB_PAGE_OFFSET = 12;
    localparam int unsigned PLB_TAG_WIDTH   = PLB_ADDR_WIDTH - PLB_PAGE_OFFSET;

    typedef struct packed {
        logic                      valid;
        logic [PLB_TAG_WIDTH-1:0]  tag;
        logic [PLB_DATA_WIDTH-1:0] data;
    } plb_cache_entry_t;

endpackage

// File: rtl/plb_victim_sel.sv
// Allocation slot picker: lowest free entry, else round-robin victim.
// Combinational select; the pointer advances only when a full cache allocates.
module plb_victim_sel
    import plb_cache_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = PLB_NUM_ENTRIES,
    parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [NUM_ENTRIES-1:0] valid_i,
    input  logic                   alloc_i,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   advance_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign advance_o = ~free_found;
    assign idx_o     = free_found ? free_idx : ptr_q;

    // Power-of-two entry count lets the increment wrap naturally.
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
        end else if (alloc_i && advance_o) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/plb_cache.sv
// Fully-associative PLB entry store answering walker lookups and fills; 1-cycle response.
// Never back-pressures except while flush_i is high, when gnt is held low.
module plb_cache
    import plb_cache_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = PLB_NUM_ENTRIES,
    parameter int unsigned DATA_WIDTH  = PLB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = PLB_ADDR_WIDTH,
    parameter int unsigned PAGE_OFFSET = PLB_PAGE_OFFSET
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    plb_slave_mem_req,
    output logic                    plb_slave_mem_gnt,
    output logic                    plb_slave_mem_valid,
    input  logic [ADDR_WIDTH-1:0]   plb_slave_mem_addr,
    output logic [DATA_WIDTH-1:0]   plb_slave_mem_rdata,
    input  logic [DATA_WIDTH-1:0]   plb_slave_mem_wdata,
    input  logic                    plb_slave_mem_we,
    input  logic [DATA_WIDTH/8-1:0] plb_slave_mem_be,
    output logic                    plb_slave_mem_error,
    output logic [31:0]             hit_count_o,
    output logic [31:0]             miss_count_o
);

    localparam int unsigned TAG_W = ADDR_WIDTH - PAGE_OFFSET;
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned NB    = DATA_WIDTH / 8;

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  data_q [NUM_ENTRIES];

    logic                  rsp_vld_q, rsp_vld_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    logic                  acc;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit_any;
    logic [IDX_W-1:0]      hit_idx;
    logic [DATA_WIDTH-1:0] be_mask;
    logic                  alloc;
    logic [IDX_W-1:0]      victim_idx;
    logic                  victim_adv;
    logic                  unused_addr_bits;

    assign plb_slave_mem_gnt = plb_slave_mem_req & ~flush_i & rst_ni;
    assign acc               = plb_slave_mem_gnt;
    assign req_tag           = plb_slave_mem_addr[ADDR_WIDTH-1:PAGE_OFFSET];
    assign unused_addr_bits  = ^plb_slave_mem_addr[PAGE_OFFSET-1:0];

    // Lowest matching index wins should duplicates ever appear.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[b*8 +: 8] = {8{plb_slave_mem_be[b]}};
        end
    end

    assign alloc = acc & plb_slave_mem_we & ~hit_any;

    plb_victim_sel #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_victim_sel (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush_i   (flush_i),
        .valid_i   (valid_q),
        .alloc_i   (alloc),
        .idx_o     (victim_idx),
        .advance_o (victim_adv)
    );

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (alloc) begin
            valid_d[victim_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_vld_d  = acc;
        rsp_err_d  = 1'b0;
        rsp_dat_d  = '0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (acc && !plb_slave_mem_we) begin
            if (hit_any) begin
                rsp_dat_d = data_q[hit_idx];
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            end else begin
                rsp_err_d = 1'b1;
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (acc && plb_slave_mem_we) begin
                if (hit_any) begin
                    data_q[hit_idx] <= (data_q[hit_idx] & ~be_mask) | (plb_slave_mem_wdata & be_mask);
                end else begin
                    tag_q[victim_idx]  <= req_tag;
                    data_q[victim_idx] <= plb_slave_mem_wdata & be_mask;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_dat_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_dat_q  <= rsp_dat_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign plb_slave_mem_valid = rsp_vld_q;
    assign plb_slave_mem_error = rsp_err_q;
    assign plb_slave_mem_rdata = rsp_dat_q;
    assign hit_count_o         = hit_cnt_q;
    assign miss_count_o        = miss_cnt_q;

endmodule

// File: doc/plb_cache.md
Name: plb_cache

Overview:
Protection Lookaside Buffer storage: the responder end of the PLB cache memory port that the MPT walker drives as a master.
- Holds NUM_ENTRIES fully-associative entries, each a tag (page number of addr) plus a 64-bit PLB entry word.
- Answers walker lookups (reads) with hit/miss and accepts fills/updates (writes) after walks.
- Sits beside mptw_top and connects to its plb_master mem port.

Parameters:
NUM_ENTRIES, 8, number of entries (power of 2, >=2)
DATA_WIDTH, 64, entry data width (mem_rdata/mem_wdata)
ADDR_WIDTH, 64, lookup key width (mem_addr)
PAGE_OFFSET, 12, low addr bits ignored; tag = addr[ADDR_WIDTH-1:PAGE_OFFSET]

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  invalidate all entries
plb_slave_mem_req  in  1  request
plb_slave_mem_gnt  out  1  request accepted this cycle
plb_slave_mem_valid  out  1  response valid
plb_slave_mem_addr  in  ADDR_WIDTH  lookup/fill key
plb_slave_mem_rdata  out  DATA_WIDTH  entry data on read hit
plb_slave_mem_wdata  in  DATA_WIDTH  fill data
plb_slave_mem_we  in  1  1=fill/update, 0=lookup
plb_slave_mem_be  in  DATA_WIDTH/8  byte enables for writes
plb_slave_mem_error  out  1  with valid: 1=read miss
hit_count_o  out  32  read hits since reset/flush, saturating
miss_count_o  out  32  read misses since reset/flush, saturating

Behaviour:
- Reset (async, rst_ni=0): all valid bits 0, victim pointer 0.
  - Outputs: gnt 0, valid 0, rdata 0, error 0, counters 0.
  - A response pending when reset asserts is dropped.
- Grant: gnt = req & ~flush_i & rst_ni (combinational). No back-pressure otherwise.
  - A request is accepted on every cycle with req&gnt.
  - Back-to-back requests are allowed.
- Latency: exactly 1 cycle. valid is registered, high in cycle N+1 iff req&gnt in cycle N. rdata/error are registered alongside valid.
- Lookup (we=0):
  - Compare tag against all valid entries.
  - Hit: rdata=entry data, error=0, hit_count+1.
  - Miss: rdata=0, error=1, miss_count+1.
  - Multiple hits cannot occur (writes de-duplicate); if forced, the lowest index wins.
- Fill (we=1):
  - Tag hit: update the hitting entry's bytes where be=1; other bytes are kept.
  - Tag miss: allocate the lowest-index invalid entry. If none is invalid, allocate entry[victim] and advance victim by 1 (mod NUM_ENTRIES, wraps).
  - On allocation: bytes with be=0 are written 0; tag is set; valid=1.
  - Response: valid with error=0, rdata=0. Counters unchanged.
- Commit timing: state updates at the accepting clock edge. A lookup granted the next cycle sees the new entry.
- Flush:
  - flush_i=1 clears all valid bits and both counters at the next edge, and resets the victim pointer to 0.
  - gnt=0 while flush_i=1, so a request in the same cycle is not accepted; the master holds req.
  - A response already pending (accepted the prior cycle) still completes with its computed value.
- Counters saturate at 2^32-1.
- Unused mem_addr low bits (below PAGE_OFFSET) are ignored in both lookup and fill.
- No X on outputs after reset; rdata is 0 whenever valid=0.

Decomposition:
- mpt_pkg gets: plb_cache_entry_t (valid, tag, data), PLB_NUM_ENTRIES, PLB_PAGE_OFFSET.
- Mem port uses the existing DEFINE_MEM_SLAVE_PORTS macro with prefix plb_slave.
- One sub-module: plb_victim_sel.
  - Inputs: valid vector, round-robin pointer.
  - Outputs: selected index and pointer-advance flag.
  - Combinational first-free priority encoder plus pointer register.

Test Plan:
- Reset then lookup addr 0x1000 -> next cycle valid=1, error=1, rdata=0; miss_count=1, hit_count=0.
- Fill addr 0x1000, wdata 0xDEAD_BEEF_0000_0001, be=0xFF; next-cycle lookup 0x1FFF -> valid, error=0, rdata=0xDEAD_BEEF_0000_0001, hit_count=1.
- Partial update: fill 0x1000 with wdata 0x1111_1111_1111_1111, be=0x0F, then lookup -> rdata 0xDEAD_BEEF_1111_1111.
- Fill 9 distinct pages 0x1000..0x9000 (NUM_ENTRIES=8):
  - Lookup 0x1000 -> miss (victim 0 replaced).
  - Lookup 0x2000..0x9000 -> all hit.
  - Victim pointer reads 1.
- Flush asserted together with a req: gnt=0 that cycle. Following lookup of a previously filled page -> error=1; counters show hit 0, miss 1.
- Async reset mid-stream: assert rst_ni=0 one cycle after a grant -> valid drops immediately, no response is emitted after release, all entries miss.
